// File: rtl/data_bus_demux.sv
// rtl/data_bus_demux.sv - data-port demux to data memory, AES peripheral and an error responder
// Responses return in request order via a small tracking FIFO of target IDs.
module data_bus_demux #(
    parameter logic [31:0] MEM_BASE    = 32'h0000_0000,
    parameter logic [31:0] MEM_MASK    = 32'hFFFF_E000,
    parameter logic [31:0] PERIPH_BASE = 32'h1000_0000,
    parameter logic [31:0] PERIPH_MASK = 32'hFFFF_FF00,
    parameter int unsigned MAX_OUTST   = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        host_req_i,
    output logic        host_gnt_o,
    input  logic [31:0] host_addr_i,
    input  logic        host_we_i,
    input  logic [3:0]  host_be_i,
    input  logic [31:0] host_wdata_i,
    output logic        host_rvalid_o,
    output logic [31:0] host_rdata_o,
    output logic        host_err_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,
    output logic        periph_req_o,
    input  logic        periph_gnt_i,
    output logic [31:0] periph_addr_o,
    output logic        periph_we_o,
    output logic [3:0]  periph_be_o,
    output logic [31:0] periph_wdata_o,
    input  logic        periph_rvalid_i,
    input  logic [31:0] periph_rdata_i,
    input  logic        periph_err_i,
    output logic [2:0]  outstanding_o,
    output logic        proto_err_o
);
    localparam int unsigned   PW    = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam logic [2:0]    DEPTH = 3'(MAX_OUTST);
    localparam logic [PW-1:0] LAST  = PW'(MAX_OUTST - 1);

    typedef enum logic [1:0] {TGT_MEM, TGT_PERIPH, TGT_ERR} tgt_e;

    tgt_e          dec;
    tgt_e          head;
    tgt_e          fifo_q [MAX_OUTST];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [2:0]    count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          stray;

    always_comb begin
        if ((host_addr_i & MEM_MASK) == MEM_BASE) begin
            dec = TGT_MEM;
        end else if ((host_addr_i & PERIPH_MASK) == PERIPH_BASE) begin
            dec = TGT_PERIPH;
        end else begin
            dec = TGT_ERR;
        end
    end

    assign full  = (count == DEPTH);
    assign empty = (count == 3'd0);
    assign head  = fifo_q[rd_ptr];

    assign mem_req_o      = host_req_i & (dec == TGT_MEM) & ~full;
    assign periph_req_o   = host_req_i & (dec == TGT_PERIPH) & ~full;
    assign mem_addr_o     = host_addr_i;
    assign mem_we_o       = host_we_i;
    assign mem_be_o       = host_be_i;
    assign mem_wdata_o    = host_wdata_i;
    assign periph_addr_o  = host_addr_i;
    assign periph_we_o    = host_we_i;
    assign periph_be_o    = host_be_i;
    assign periph_wdata_o = host_wdata_i;

    // Unmapped addresses are granted locally and answered with an error later.
    always_comb begin
        case (dec)
            TGT_MEM:    host_gnt_o = ~full & mem_gnt_i;
            TGT_PERIPH: host_gnt_o = ~full & periph_gnt_i;
            default:    host_gnt_o = ~full;
        endcase
    end

    always_comb begin
        host_rvalid_o = 1'b0;
        host_rdata_o  = 32'h0;
        host_err_o    = 1'b0;
        if (!empty) begin
            case (head)
                TGT_MEM: begin
                    host_rvalid_o = mem_rvalid_i;
                    host_rdata_o  = mem_rdata_i;
                    host_err_o    = mem_err_i;
                end
                TGT_PERIPH: begin
                    host_rvalid_o = periph_rvalid_i;
                    host_rdata_o  = periph_rdata_i;
                    host_err_o    = periph_err_i;
                end
                default: begin
                    host_rvalid_o = 1'b1;
                    host_err_o    = 1'b1;
                end
            endcase
        end
    end

    assign push  = host_req_i & host_gnt_o;
    assign pop   = host_rvalid_o;
    assign stray = (mem_rvalid_i & (empty | (head != TGT_MEM))) |
                   (periph_rvalid_i & (empty | (head != TGT_PERIPH)));
    assign outstanding_o = count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= 3'd0;
            proto_err_o <= 1'b0;
            for (int i = 0; i < int'(MAX_OUTST); i++) begin
                fifo_q[i] <= TGT_ERR;
            end
        end else begin
            if (push) begin
                fifo_q[wr_ptr] <= dec;
                wr_ptr         <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 3'd1;
            end else if (pop && !push) begin
                count <= count - 3'd1;
            end
            if (stray) begin
                proto_err_o <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_data_bus_demux.sv
// tb/tb_data_bus_demux.sv - directed scenarios plus randomized traffic against an in-order queue model
module tb_data_bus_demux;
    logic        clk = 1'b0;
    logic        rst_ni;
    logic        host_req, host_gnt, host_we, host_rvalid, host_err;
    logic [31:0] host_addr, host_wdata, host_rdata;
    logic [3:0]  host_be;
    logic        mem_req, mem_gnt, mem_we, mem_rvalid, mem_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        periph_req, periph_gnt, periph_we, periph_rvalid, periph_err;
    logic [31:0] periph_addr, periph_wdata, periph_rdata;
    logic [3:0]  periph_be;
    logic [2:0]  outstanding;
    logic        proto_err;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    data_bus_demux dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .host_req_i(host_req), .host_gnt_o(host_gnt), .host_addr_i(host_addr),
        .host_we_i(host_we), .host_be_i(host_be), .host_wdata_i(host_wdata),
        .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata), .host_err_o(host_err),
        .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
        .mem_be_o(mem_be), .mem_wdata_o(mem_wdata), .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata), .mem_err_i(mem_err),
        .periph_req_o(periph_req), .periph_gnt_i(periph_gnt), .periph_addr_o(periph_addr),
        .periph_we_o(periph_we), .periph_be_o(periph_be), .periph_wdata_o(periph_wdata),
        .periph_rvalid_i(periph_rvalid), .periph_rdata_i(periph_rdata), .periph_err_i(periph_err),
        .outstanding_o(outstanding), .proto_err_o(proto_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        host_req = 0; host_addr = 0; host_we = 0; host_be = 0; host_wdata = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; mem_err = 0;
        periph_gnt = 0; periph_rvalid = 0; periph_rdata = 0; periph_err = 0;
    endtask

    task automatic do_reset();
        rst_ni = 0;
        idle();
        step();
        step();
        rst_ni = 1;
        step();
    endtask

    // Address classes: 0 memory, 1 peripheral, 2 unmapped (error)
    function automatic int model_decode(logic [31:0] a);
        if ((a & 32'hFFFF_E000) == 32'h0000_0000) return 0;
        if ((a & 32'hFFFF_FF00) == 32'h1000_0000) return 1;
        return 2;
    endfunction

    task automatic test_reset();
        rst_ni = 0;
        idle();
        #3;
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL rst_outstanding got=%0d exp=0", outstanding); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rst_proto_err got=%b exp=0", proto_err); end
        checks++; if ({host_rvalid, host_err, host_rdata} !== 34'h0) begin errors++; $display("FAIL rst_host_resp got=%b/%b/%h exp=0/0/0", host_rvalid, host_err, host_rdata); end
        step();
        rst_ni = 1;
        step();
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL post_rst_outstanding got=%0d exp=0", outstanding); end
    endtask

    task automatic test_mem_read();
        host_req = 1; host_addr = 32'h0000_0010; host_we = 0; host_be = 4'hF; mem_gnt = 1;
        #3;
        checks++; if (mem_req !== 1'b1 || periph_req !== 1'b0) begin errors++; $display("FAIL memrd_req got=%b/%b exp=1/0", mem_req, periph_req); end
        checks++; if (host_gnt !== 1'b1) begin errors++; $display("FAIL memrd_gnt got=%b exp=1", host_gnt); end
        step();
        host_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D; mem_err = 0;
        #3;
        checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL memrd_outst1 got=%0d exp=1", outstanding); end
        checks++; if (host_rvalid !== 1'b1 || host_rdata !== 32'hCAFE_F00D || host_err !== 1'b0) begin errors++; $display("FAIL memrd_resp got=%b/%h/%b exp=1/cafef00d/0", host_rvalid, host_rdata, host_err); end
        step();
        mem_rvalid = 0;
        #3;
        checks++; if (outstanding !== 3'd0 || host_rvalid !== 1'b0) begin errors++; $display("FAIL memrd_done got=%0d/%b exp=0/0", outstanding, host_rvalid); end
        step();
    endtask

    task automatic test_periph_write();
        logic [31:0] d;
        host_req = 1; host_addr = 32'h1000_0004; host_we = 1; host_be = 4'hF; host_wdata = 32'h0123_4567; periph_gnt = 1;
        #3;
        checks++; if (periph_req !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL pwr_req got=%b/%b exp=1/0", periph_req, mem_req); end
        checks++; if (periph_addr !== 32'h1000_0004 || periph_we !== 1'b1 || periph_be !== 4'hF || periph_wdata !== 32'h0123_4567) begin errors++; $display("FAIL pwr_fields got=%h/%b/%h/%h exp=10000004/1/f/01234567", periph_addr, periph_we, periph_be, periph_wdata); end
        checks++; if (mem_addr !== 32'h1000_0004 || mem_wdata !== 32'h0123_4567) begin errors++; $display("FAIL pwr_mem_fwd got=%h/%h exp=10000004/01234567", mem_addr, mem_wdata); end
        checks++; if (host_gnt !== 1'b1) begin errors++; $display("FAIL pwr_gnt got=%b exp=1", host_gnt); end
        step();
        d = $urandom;
        idle(); periph_rvalid = 1; periph_rdata = d;
        #3;
        checks++; if (host_rvalid !== 1'b1 || host_rdata !== d || host_err !== 1'b0) begin errors++; $display("FAIL pwr_resp got=%b/%h/%b exp=1/%h/0", host_rvalid, host_rdata, host_err, d); end
        step();
        periph_rvalid = 0;
        #3;
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL pwr_done got=%0d exp=0", outstanding); end
        step();
    endtask

    task automatic test_err_decode();
        host_req = 1; host_addr = 32'h2000_0000; host_we = 0;
        #3;
        checks++; if (mem_req !== 1'b0 || periph_req !== 1'b0) begin errors++; $display("FAIL err_req got=%b/%b exp=0/0", mem_req, periph_req); end
        checks++; if (host_gnt !== 1'b1 || host_rvalid !== 1'b0) begin errors++; $display("FAIL err_gnt got=%b rvalid=%b exp=1/0", host_gnt, host_rvalid); end
        step();
        host_req = 0;
        #3;
        checks++; if (host_rvalid !== 1'b1 || host_err !== 1'b1 || host_rdata !== 32'h0) begin errors++; $display("FAIL err_resp got=%b/%b/%h exp=1/1/0", host_rvalid, host_err, host_rdata); end
        step();
        #3;
        checks++; if (outstanding !== 3'd0 || host_rvalid !== 1'b0) begin errors++; $display("FAIL err_done got=%0d/%b exp=0/0", outstanding, host_rvalid); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] pd, md;
        pd = $urandom; md = $urandom;
        host_req = 1; host_addr = 32'h1000_0008; host_we = 0; periph_gnt = 1;
        #3;
        checks++; if (host_gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt1 got=%b exp=1", host_gnt); end
        step();
        host_addr = 32'h0000_0020; periph_gnt = 0; mem_gnt = 1;
        #3;
        checks++; if (host_gnt !== 1'b1 || outstanding !== 3'd1) begin errors++; $display("FAIL b2b_gnt2 got=%b/%0d exp=1/1", host_gnt, outstanding); end
        step();
        host_addr = 32'h0000_0024;
        #3;
        checks++; if (outstanding !== 3'd2 || host_gnt !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL b2b_stall got=%0d/%b/%b exp=2/0/0", outstanding, host_gnt, mem_req); end
        step();
        step();
        periph_rvalid = 1; periph_rdata = pd;
        #3;
        checks++; if (host_rvalid !== 1'b1 || host_rdata !== pd) begin errors++; $display("FAIL b2b_presp got=%b/%h exp=1/%h", host_rvalid, host_rdata, pd); end
        checks++; if (host_gnt !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL b2b_full_pop got=%b/%b exp=0/0", host_gnt, mem_req); end
        step();
        periph_rvalid = 0; host_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = md;
        #3;
        checks++; if (outstanding !== 3'd1 || host_rvalid !== 1'b1 || host_rdata !== md) begin errors++; $display("FAIL b2b_mresp got=%0d/%b/%h exp=1/1/%h", outstanding, host_rvalid, host_rdata, md); end
        step();
        mem_rvalid = 0;
        #3;
        checks++; if (outstanding !== 3'd0 || proto_err !== 1'b0) begin errors++; $display("FAIL b2b_done got=%0d/%b exp=0/0", outstanding, proto_err); end
        step();
    endtask

    task automatic test_proto_err();
        mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
        #3;
        checks++; if (host_rvalid !== 1'b0 || host_rdata !== 32'h0) begin errors++; $display("FAIL perr_drop got=%b/%h exp=0/0", host_rvalid, host_rdata); end
        step();
        mem_rvalid = 0;
        #3;
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL perr_set got=%b exp=1", proto_err); end
        step(); step();
        #3;
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL perr_sticky got=%b exp=1", proto_err); end
        do_reset();
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL perr_clear got=%b exp=0", proto_err); end
    endtask

    task automatic test_reset_inflight();
        host_req = 1; host_addr = 32'h0000_0100; mem_gnt = 1;
        step(); step();
        idle(); mem_rvalid = 1; mem_rdata = 32'h5555_AAAA;
        #2;
        checks++; if (outstanding !== 3'd2 || host_rvalid !== 1'b1) begin errors++; $display("FAIL rif_pre got=%0d/%b exp=2/1", outstanding, host_rvalid); end
        rst_ni = 0;
        #1;
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL rif_outst got=%0d exp=0", outstanding); end
        checks++; if ({host_rvalid, host_err, host_rdata} !== 34'h0 || proto_err !== 1'b0) begin errors++; $display("FAIL rif_outputs got=%b/%b/%h perr=%b exp=0/0/0/0", host_rvalid, host_err, host_rdata, proto_err); end
        step();
        rst_ni = 1;
        step();
        mem_rvalid = 0;
        #3;
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL rif_late_resp got=%b exp=1", proto_err); end
        do_reset();
    endtask

    task automatic test_random();
        int          q[$];
        int          dec, head, k;
        logic        perr_exp, full, gnt_exp, mreq_exp, preq_exp, rv_exp, err_exp, stray;
        logic [31:0] rd_exp;
        perr_exp = 0;
        for (int c = 0; c < 2000; c++) begin
            k = $urandom_range(0, 3);
            host_req   = ($urandom_range(0, 3) != 0);
            host_addr  = (k == 0) ? ($urandom & 32'h0000_1FFF) :
                         (k == 1) ? (32'h1000_0000 | ($urandom & 32'hFF)) :
                         (k == 2) ? (32'h2000_0000 | ($urandom & 32'hFFFF)) : $urandom;
            host_we    = $urandom; host_be = $urandom; host_wdata = $urandom;
            mem_gnt    = $urandom; periph_gnt = $urandom;
            head       = (q.size() != 0) ? q[0] : -1;
            mem_rvalid    = (head == 0) && ($urandom_range(0, 2) == 0);
            periph_rvalid = (head == 1) && ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 49) == 0) begin
                if (head == 0) periph_rvalid = 1; else mem_rvalid = 1;
            end
            mem_rdata = $urandom; mem_err = $urandom;
            periph_rdata = $urandom; periph_err = $urandom;

            dec      = model_decode(host_addr);
            full     = (q.size() == 2);
            gnt_exp  = !full && ((dec == 0) ? mem_gnt : (dec == 1) ? periph_gnt : 1'b1);
            mreq_exp = host_req && dec == 0 && !full;
            preq_exp = host_req && dec == 1 && !full;
            rv_exp   = (head == 0) ? mem_rvalid : (head == 1) ? periph_rvalid : (head == 2);
            rd_exp   = (head == 0) ? mem_rdata : (head == 1) ? periph_rdata : 32'h0;
            err_exp  = (head == 0) ? mem_err : (head == 1) ? periph_err : (head == 2);
            stray    = (mem_rvalid && head != 0) || (periph_rvalid && head != 1);
            #3;
            checks++; if (outstanding !== 3'(q.size())) begin errors++; $display("FAIL rnd_outst c=%0d got=%0d exp=%0d", c, outstanding, q.size()); end
            checks++; if (host_gnt !== gnt_exp) begin errors++; $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, host_gnt, gnt_exp); end
            checks++; if (mem_req !== mreq_exp || periph_req !== preq_exp) begin errors++; $display("FAIL rnd_req c=%0d got=%b/%b exp=%b/%b", c, mem_req, periph_req, mreq_exp, preq_exp); end
            checks++; if (host_rvalid !== rv_exp) begin errors++; $display("FAIL rnd_rvalid c=%0d got=%b exp=%b", c, host_rvalid, rv_exp); end
            checks++; if (host_rdata !== rd_exp || host_err !== err_exp) begin errors++; $display("FAIL rnd_rdata c=%0d got=%h/%b exp=%h/%b", c, host_rdata, host_err, rd_exp, err_exp); end
            checks++; if (proto_err !== perr_exp) begin errors++; $display("FAIL rnd_proto_err c=%0d got=%b exp=%b", c, proto_err, perr_exp); end
            if (rv_exp) void'(q.pop_front());
            if (host_req && gnt_exp) q.push_back(dec);
            if (stray) perr_exp = 1;
            step();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_mem_read();
        test_periph_write();
        test_err_decode();
        test_back_to_back();
        test_proto_err();
        test_reset_inflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
